// File: rtl/onoff_spike_encoder.sv
// onoff_spike_encoder
//   Transmitter side of the temporal-coded 3x3 on/off filter interface.
//   Accepts one 3x3 pixel patch per valid/ready handshake, converts every
//   pixel to a spike time (brighter -> earlier), then plays one wave of
//   monotonic step signals on the center/edge lanes of the filter. A
//   one-cycle clear pulse to the filter precedes every wave.
//
// Ports
//   clk                clock
//   rst                asynchronous active-high reset
//   patch_in           9 pixels, pixel k at [PIX_W*k +: PIX_W]; k=0..7 edges, k=8 center
//   in_valid           patch_in valid
//   in_ready           encoder can accept a patch (IDLE only)
//   filter_rst_out     one-cycle clear pulse ahead of each wave
//   filter_center_out  center step signal
//   filter_edge_out    edge step signals, filter_edge_out[j] carries pixel j
//   wave_active        high while the wave runs
//   wave_time          current wave cycle index, 0 outside the wave
//   wave_done          one-cycle pulse when the wave ends
module onoff_spike_encoder #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned T_W   = 6,
    parameter int unsigned TAIL  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9*PIX_W-1:0] patch_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               filter_rst_out,
    output logic               filter_center_out,
    output logic [0:7]         filter_edge_out,
    output logic               wave_active,
    output logic [T_W:0]       wave_time,
    output logic               wave_done
);

    // Last RUN cycle index: the full time window plus the settling tail.
    localparam logic [T_W:0] LAST_T = (T_W+1)'(2**T_W - 1 + TAIL);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [T_W-1:0]   spike_t [9];   // latched spike times
    logic [T_W-1:0]   patch_t [9];   // spike times of the incoming patch
    logic [T_W:0]     next_t;        // wave_time of the upcoming RUN cycle
    logic             center_nxt;
    logic [0:7]       edge_nxt;

    // time = (2**PIX_W-1 - pix) >> (PIX_W-T_W); the result always fits T_W bits.
    always_comb begin
        for (int unsigned k = 0; k < 9; k++) begin
            patch_t[k] = T_W'(({PIX_W{1'b1}} - patch_in[PIX_W*k +: PIX_W]) >> (PIX_W - T_W));
        end
    end

    // Step values are computed for the cycle about to be entered so the
    // registered lanes line up with the registered wave_time.
    always_comb begin
        next_t = (state == CLR) ? '0 : wave_time + (T_W+1)'(1);
        center_nxt = ({1'b0, spike_t[8]} <= next_t);
        edge_nxt   = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            edge_nxt[j] = ({1'b0, spike_t[j]} <= next_t);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            in_ready          <= 1'b1;
            filter_rst_out    <= 1'b0;
            filter_center_out <= 1'b0;
            filter_edge_out   <= '0;
            wave_active       <= 1'b0;
            wave_time         <= '0;
            wave_done         <= 1'b0;
            for (int unsigned k = 0; k < 9; k++) begin
                spike_t[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        spike_t        <= patch_t;
                        state          <= CLR;
                        in_ready       <= 1'b0;
                        filter_rst_out <= 1'b1;
                    end
                end
                CLR: begin
                    state             <= RUN;
                    filter_rst_out    <= 1'b0;
                    wave_active       <= 1'b1;
                    wave_time         <= next_t;
                    filter_center_out <= center_nxt;
                    filter_edge_out   <= edge_nxt;
                end
                RUN: begin
                    if (wave_time == LAST_T) begin
                        state             <= DONE;
                        wave_active       <= 1'b0;
                        wave_time         <= '0;
                        filter_center_out <= 1'b0;
                        filter_edge_out   <= '0;
                        wave_done         <= 1'b1;
                    end else begin
                        wave_time         <= next_t;
                        filter_center_out <= center_nxt;
                        filter_edge_out   <= edge_nxt;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    wave_done <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
